pipeline_mdu_iter: RTL
======================

Name: pipeline_mdu_iter

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers; adds MULT/MULTU/DIV/DIVU/MTHI/MTLO to the 5-stage MIPS pipeline.
- Operands are taken from the EX stage after forwarding.
- busy goes to the hazard unit, which stalls MFHI/MFLO and any new MDU op while busy=1.
- abort is driven by the IRQ/flush logic and cancels an in-flight op with no architectural effect.

Parameters:
- DATA_W, 32, operand/HI/LO width; must be ≥4 and even.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle op request from EX.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 treated as no-op.
- abort  input  1  cancel current op (flush/IRQ).
- src_a  input  DATA_W  rs value: dividend / multiplicand / MTHI/MTLO data.
- src_b  input  DATA_W  rt value: divisor / multiplier.
- busy  output  1  iterative op in progress.
- done  output  1  one-cycle pulse after HI/LO are written.
- hi  output  DATA_W  HI register.
- lo  output  DATA_W  LO register.

Behaviour:
- Reset (async, any state, including mid-op): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, all datapath registers cleared.
- States: IDLE, CALC, FIX.
- IDLE, start=1 and abort=0, op 0–3, at edge E0:
  - Latch operand magnitudes (signed ops) or raw values (unsigned ops), the result sign, and the remainder sign.
  - counter=0, go to CALC, busy=1.
- IDLE, start=1, op 4/5 at edge E0: hi (or lo)=src_a, done=1 for one cycle, busy stays 0, state stays IDLE.
- CALC: one iteration per cycle; counter increments each cycle; after DATA_W iterations (edge E0+DATA_W) go to FIX.
  - MULT/MULTU: shift-add over a 2*DATA_W product register.
  - DIV/DIVU: restoring shift-subtract.
- FIX, edge E0+DATA_W+1:
  - Apply sign correction and write hi/lo.
  - done=1 for this one cycle, busy=0, go to IDLE.
  - Total latency is DATA_W+1 cycles (33 at default). hi/lo keep old values until this edge.
- Arithmetic rules:
  - MULT/MULTU: {hi,lo} = full 2*DATA_W product.
  - DIV/DIVU: lo=quotient, hi=remainder. Signed division truncates toward zero; remainder takes the sign of the dividend.
  - Signed MIN/−1: lo=MIN, hi=0.
  - Divisor 0 (signed or unsigned): lo=all ones, hi=src_a unchanged, with the same latency.
- start while busy=1: ignored, no state change.
- abort:
  - Has priority over start in every state.
  - In CALC/FIX: go to IDLE at the next edge, busy=0, no done, hi/lo unchanged.
  - In IDLE with start: request dropped, including MTHI/MTLO.
- A new start is accepted in the cycle done=1, since the unit is already IDLE.

Decomposition:
- Shared package mdu_pkg holds:
  - Op encodings (MDU_MULT … MDU_MTLO).
  - State encodings (S_IDLE, S_CALC, S_FIX).
  - Helper constant for the default DATA_W.
- One sub-module is natural: pipeline_mdu_core, the DATA_W-parametrised shift/add-subtract datapath (one iteration per enable, mode=mul/div).
  - Sign preprocessing, divide-by-zero override, FSM and HI/LO registers stay in the top.

Test Plan:
- MULT src_a=FFFFFFFD (−3), src_b=7 → after 33 cycles done=1, hi=FFFFFFFF, lo=FFFFFFEB; busy=1 for exactly cycles 1–32.
- MULTU FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001.
- DIV FFFFFFF9 (−7) / 2 → lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- DIVU 64/0 → lo=FFFFFFFF, hi=00000064.
- Abort and reset:
  - Preload hi=1111, lo=2222 via MTHI/MTLO (each gives done after 1 cycle, busy never 1).
  - Start DIVU 10/3, abort at cycle 10 → busy=0 next cycle, no done, hi=1111, lo=2222.
  - Repeat with reset asserted mid-CALC → hi=lo=0 immediately.
- Start again while busy (MULT 2×2 during DIVU 9/2) → ignored; result hi=1, lo=4 at cycle 33. Back-to-back start in the done cycle → accepted.

Source files
------------

// File: rtl/pipeline_mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// datapath mode and default widths.
package mdu_pkg;

  localparam int MDU_DATA_W_DEF = 32;
  localparam int MDU_CNT_W_DEF  = 6;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_NOP6  = 3'd6,
    MDU_NOP7  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mdu_mode_e;

endpackage

// File: rtl/pipeline_mdu_iter_if.sv
// EX-stage <-> MDU request/result bundle; master is the pipeline, slave is the MDU.
interface pipeline_mdu_iter_if
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W_DEF
) ();

  logic              start;
  mdu_op_e           op;
  logic              abort;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, abort, src_a, src_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, abort, src_a, src_b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/pipeline_mdu_core.sv
// Unsigned iterative datapath: one shift-add (mul) or restoring shift-subtract (div)
// step per enable. Result sits in {acc, q}: product, or remainder/quotient.
module pipeline_mdu_core
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  mdu_mode_e         mode,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] opb_r;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   shifted;
  logic              fits;
  logic [DATA_W-1:0] rem_sub;
  logic [DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0] q_nxt;

  // mul: q holds the multiplier and fills with product low bits as it shifts right.
  // div: q holds the dividend and fills with quotient bits as it shifts left.
  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, opb_r} : '0);
    shifted = {acc, q[DATA_W-1]};
    fits    = (shifted >= {1'b0, opb_r});
    rem_sub = shifted[DATA_W-1:0] - opb_r;
    acc_nxt = acc;
    q_nxt   = q;
    if (mode == MODE_MUL) begin
      acc_nxt = sum[DATA_W:1];
      q_nxt   = {sum[0], q[DATA_W-1:1]};
    end else if (fits) begin
      acc_nxt = rem_sub;
      q_nxt   = {q[DATA_W-2:0], 1'b1};
    end else begin
      acc_nxt = shifted[DATA_W-1:0];
      q_nxt   = {q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      q     <= '0;
      opb_r <= '0;
    end else if (load) begin
      acc   <= '0;
      q     <= opa;
      opb_r <= opb;
    end else if (en) begin
      acc   <= acc_nxt;
      q     <= q_nxt;
    end
  end

endmodule

// File: rtl/pipeline_mdu_iter.sv
// Iterative MIPS multiply/divide unit with HI/LO: sign handling, divide-by-zero
// override, control FSM and architectural registers around pipeline_mdu_core.
module pipeline_mdu_iter
  import mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W_DEF,
  parameter int CNT_W  = MDU_CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  pipeline_mdu_iter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  mdu_state_e        state;
  mdu_state_e        state_nxt;
  logic [CNT_W-1:0]  cnt;
  mdu_mode_e         mode_r;
  logic              neg_res;
  logic              neg_rem;
  logic              div_zero;
  logic [DATA_W-1:0] a_raw;
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;
  logic              done_r;

  logic [2:0]        op_bits;
  logic              accept;
  logic              iter_op;
  logic              signed_op;
  logic              div_op;
  logic              a_neg;
  logic              b_neg;
  logic              mt_hi;
  logic              mt_lo;
  logic              core_load;
  logic              core_en;
  logic              wr_res;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] quo;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic signed [2*DATA_W-1:0] cond_neg_wide(
    input logic signed [2*DATA_W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign op_bits = bus.op;

  // Request decode; abort masks every start.
  always_comb begin
    accept    = (state == S_IDLE) && bus.start && !bus.abort;
    iter_op   = !op_bits[2];
    signed_op = iter_op && !op_bits[0];
    div_op    = iter_op && op_bits[1];
    a_neg     = signed_op && bus.src_a[DATA_W-1];
    b_neg     = signed_op && bus.src_b[DATA_W-1];
    mag_a     = cond_neg(bus.src_a, a_neg);
    mag_b     = cond_neg(bus.src_b, b_neg);
    mt_hi     = accept && (bus.op == MDU_MTHI);
    mt_lo     = accept && (bus.op == MDU_MTLO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_load = 1'b0;
    core_en   = 1'b0;
    wr_res    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && iter_op) begin
          state_nxt = S_CALC;
          core_load = 1'b1;
        end
      end
      S_CALC: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else begin
          core_en = 1'b1;
          if (cnt == LAST_ITER) state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        state_nxt = S_IDLE;
        wr_res    = !bus.abort;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      mode_r   <= MODE_MUL;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
    end else if (core_load) begin
      cnt      <= '0;
      mode_r   <= div_op ? MODE_DIV : MODE_MUL;
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= div_op && (bus.src_b == '0);
      a_raw    <= bus.src_a;
    end else if (core_en) begin
      cnt      <= cnt + CNT_W'(1);
    end
  end

  pipeline_mdu_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (core_load),
    .en    (core_en),
    .mode  (mode_r),
    .opa   (mag_a),
    .opb   (mag_b),
    .acc   (acc),
    .q     (quo)
  );

  // Sign correction; a zero divisor returns the dividend untouched in HI.
  always_comb begin
    prod_s = cond_neg_wide($signed({acc, quo}), neg_res);
    res_hi = '0;
    res_lo = '0;
    if (mode_r == MODE_MUL) begin
      {res_hi, res_lo} = prod_s;
    end else if (div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_hi = cond_neg(acc, neg_rem);
      res_lo = cond_neg(quo, neg_res);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= wr_res || mt_hi || mt_lo;
      if (wr_res) begin
        hi_r <= res_hi;
        lo_r <= res_lo;
      end else begin
        if (mt_hi) hi_r <= bus.src_a;
        if (mt_lo) lo_r <= bus.src_a;
      end
    end
  end

  assign bus.busy = (state == S_CALC);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
